// File: rtl/mem_word_ctrl.sv
// 16-bit word port in front of a 64-bit block memory: one-line read buffer,
// write-through stores (read-modify-write on a buffer miss) and a wait-state timeout.
module mem_word_ctrl #(
  parameter bit          INIT_WAIT_EN = 1'b1,
  parameter int unsigned MEM_TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_is_rd,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_done,
  output logic [15:0] cpu_rdata,
  output logic        cpu_err,
  output logic        mem_start,
  output logic        mem_is_rd,
  output logic [15:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_finish
);

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_WR_ISSUE = 3'd4,
    ST_WR_WAIT  = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);
  localparam state_t     RST_STATE = INIT_WAIT_EN ? ST_INIT : ST_IDLE;

  function automatic logic [15:0] lane_word(input logic [63:0] blk, input logic [1:0] lane);
    logic [15:0] w;
    case (lane)
      2'd0:    w = blk[15:0];
      2'd1:    w = blk[31:16];
      2'd2:    w = blk[47:32];
      2'd3:    w = blk[63:48];
      default: w = 16'd0;
    endcase
    return w;
  endfunction

  function automatic logic [63:0] lane_merge(input logic [63:0] blk, input logic [1:0] lane,
                                             input logic [15:0] word);
    logic [63:0] m;
    m = blk;
    case (lane)
      2'd0:    m[15:0]  = word;
      2'd1:    m[31:16] = word;
      2'd2:    m[47:32] = word;
      2'd3:    m[63:48] = word;
      default: m = blk;
    endcase
    return m;
  endfunction

  state_t      state_r, state_s;
  logic [63:0] line_r, line_s;
  logic [12:0] tag_r, tag_s;
  logic        line_valid_r, line_valid_s;
  logic        req_is_rd_r, req_is_rd_s;
  logic [15:1] req_addr_r, req_addr_s;
  logic [15:0] req_wdata_r, req_wdata_s;
  logic [7:0]  tmo_cnt_r, tmo_cnt_s, tmo_inc_s;
  logic        tmo_hit_s;
  logic        hit_s;
  logic        abort_s;
  logic        issue_s;
  logic        unused_addr_bit_s;

  // Byte lane bit 0 is meaningless for word accesses.
  assign unused_addr_bit_s = cpu_addr[0];

  // Next-state, line buffer and timeout counter logic.
  always_comb begin
    state_s      = state_r;
    line_s       = line_r;
    tag_s        = tag_r;
    line_valid_s = line_valid_r;
    req_is_rd_s  = req_is_rd_r;
    req_addr_s   = req_addr_r;
    req_wdata_s  = req_wdata_r;
    tmo_cnt_s    = tmo_cnt_r;
    abort_s      = 1'b0;
    tmo_inc_s    = tmo_cnt_r + 8'd1;
    tmo_hit_s    = (tmo_inc_s == TMO_LIMIT);
    hit_s        = line_valid_r && (tag_r == cpu_addr[15:3]);

    case (state_r)
      ST_INIT: begin
        // The memory's reset-time write must drain before we may issue anything.
        if (mem_finish || tmo_hit_s) begin
          state_s = ST_IDLE;
        end else begin
          tmo_cnt_s = tmo_inc_s;
        end
      end
      ST_IDLE: begin
        if (cpu_req && cpu_ready) begin
          req_is_rd_s = cpu_is_rd;
          req_addr_s  = cpu_addr[15:1];
          req_wdata_s = cpu_wdata;
          if (cpu_is_rd) begin
            state_s = hit_s ? ST_DONE : ST_RD_ISSUE;
          end else if (hit_s) begin
            line_s  = lane_merge(line_r, cpu_addr[2:1], cpu_wdata);
            state_s = ST_WR_ISSUE;
          end else begin
            state_s = ST_RD_ISSUE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_ISSUE: begin
        state_s   = ST_RD_WAIT;
        tmo_cnt_s = 8'd0;
      end
      ST_RD_WAIT: begin
        if (mem_finish) begin
          tag_s        = req_addr_r[15:3];
          line_valid_s = 1'b1;
          if (req_is_rd_r) begin
            line_s  = mem_rdata;
            state_s = ST_DONE;
          end else begin
            line_s  = lane_merge(mem_rdata, req_addr_r[2:1], req_wdata_r);
            state_s = ST_WR_ISSUE;
          end
        end else if (tmo_hit_s) begin
          line_valid_s = 1'b0;
          abort_s      = 1'b1;
          state_s      = ST_DONE;
        end else begin
          tmo_cnt_s = tmo_inc_s;
        end
      end
      ST_WR_ISSUE: begin
        state_s   = ST_WR_WAIT;
        tmo_cnt_s = 8'd0;
      end
      ST_WR_WAIT: begin
        if (mem_finish) begin
          state_s = ST_DONE;
        end else if (tmo_hit_s) begin
          // Memory state is unknown after a lost write, so drop the buffered copy.
          line_valid_s = 1'b0;
          abort_s      = 1'b1;
          state_s      = ST_DONE;
        end else begin
          tmo_cnt_s = tmo_inc_s;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        line_valid_s = 1'b0;
        state_s      = ST_IDLE;
      end
    endcase

    issue_s = (state_s == ST_RD_ISSUE) || (state_s == ST_WR_ISSUE);
  end

  // State, line buffer and latched request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= RST_STATE;
      line_r       <= 64'd0;
      tag_r        <= 13'd0;
      line_valid_r <= 1'b0;
      req_is_rd_r  <= 1'b0;
      req_addr_r   <= 15'd0;
      req_wdata_r  <= 16'd0;
      tmo_cnt_r    <= 8'd0;
    end else begin
      state_r      <= state_s;
      line_r       <= line_s;
      tag_r        <= tag_s;
      line_valid_r <= line_valid_s;
      req_is_rd_r  <= req_is_rd_s;
      req_addr_r   <= req_addr_s;
      req_wdata_r  <= req_wdata_s;
      tmo_cnt_r    <= tmo_cnt_s;
    end
  end

  // Output registers, decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_ready <= 1'b0;
      cpu_done  <= 1'b0;
      cpu_rdata <= 16'd0;
      cpu_err   <= 1'b0;
      mem_start <= 1'b0;
      mem_is_rd <= 1'b0;
      mem_addr  <= 16'd0;
      mem_wdata <= 64'd0;
    end else begin
      cpu_ready <= (state_s == ST_IDLE);
      cpu_done  <= (state_s == ST_DONE);
      cpu_err   <= abort_s;
      cpu_rdata <= ((state_s == ST_DONE) && req_is_rd_s && !abort_s)
                   ? lane_word(line_s, req_addr_s[2:1]) : 16'd0;
      mem_start <= issue_s;
      mem_is_rd <= (state_s == ST_RD_ISSUE);
      mem_addr  <= issue_s ? {req_addr_s[15:3], 3'b000} : 16'd0;
      mem_wdata <= (state_s == ST_WR_ISSUE) ? line_s : 64'd0;
    end
  end

endmodule

// File: tb/tb_mem_word_ctrl.sv
// Directed bench for mem_word_ctrl: behavioural block memory with fixed response
// delay, scenario tasks with hand-computed expectations.
module tb_mem_word_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_is_rd = 1'b0;
  logic [15:0] cpu_addr = 16'd0;
  logic [15:0] cpu_wdata = 16'd0;
  logic        cpu_ready, cpu_done, cpu_err;
  logic [15:0] cpu_rdata;
  logic        mem_start, mem_is_rd;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = 64'd0;
  logic        mem_finish = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_word_ctrl #(.INIT_WAIT_EN(1'b1), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_is_rd(cpu_is_rd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .mem_start(mem_start), .mem_is_rd(mem_is_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_finish(mem_finish)
  );

  always #5 clk = ~clk;

  // Memory model: word at byte address a initially holds a.
  logic [63:0] mem_store [logic [12:0]];
  int          start_cnt = 0;
  int          init_req = 0;
  int          init_ack = 0;
  int          done_cnt = 0;
  logic        hold_finish = 1'b0;
  logic [15:0] last_addr = 16'd0;
  logic [15:0] last_rd_addr = 16'd0;
  logic        last_is_rd = 1'b0;
  logic [63:0] last_wdata = 64'd0;
  logic        pend = 1'b0;
  logic        pend_rd = 1'b0;
  int          pend_delay = 0;
  logic [12:0] pend_blk = 13'd0;
  logic [63:0] pend_wdata = 64'd0;

  function automatic logic [63:0] blk_init(input logic [12:0] b);
    logic [15:0] base;
    base = {b, 3'b000};
    return {base + 16'd6, base + 16'd4, base + 16'd2, base};
  endfunction

  always @(negedge clk) begin
    mem_finish = 1'b0;
    mem_rdata  = 64'd0;
    if (rst) begin
      pend = 1'b0;
    end else if (init_ack != init_req) begin
      mem_finish = 1'b1;
      init_ack++;
    end else if (pend) begin
      if (pend_delay > 1) begin
        pend_delay--;
      end else begin
        pend = 1'b0;
        if (!hold_finish) begin
          mem_finish = 1'b1;
          if (pend_rd) mem_rdata = mem_store.exists(pend_blk) ? mem_store[pend_blk] : blk_init(pend_blk);
          else mem_store[pend_blk] = pend_wdata;
        end
      end
    end
    if (mem_start === 1'b1) begin
      start_cnt++;
      last_addr  = mem_addr;
      last_is_rd = mem_is_rd;
      if (mem_is_rd) last_rd_addr = mem_addr;
      else last_wdata = mem_wdata;
      pend       = 1'b1;
      pend_delay = 2;
      pend_rd    = mem_is_rd;
      pend_blk   = mem_addr[15:3];
      pend_wdata = mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (cpu_done === 1'b1) done_cnt++;
  end

  int          lat;
  logic [15:0] rdat;
  logic        er;

  // Issue one request and wait for its cpu_done; lat counts edges after the accept edge.
  task automatic do_req(input logic rd, input logic [15:0] a, input logic [15:0] wd,
                        output int l, output logic [15:0] rv, output logic ev);
    int g;
    g = 0;
    while (cpu_ready !== 1'b1 && g < 100) begin
      @(posedge clk); #1; g++;
    end
    n_checks++;
    if (g >= 100) begin
      n_fail++;
      $display("FAIL ready_wait: cpu_ready=%b, required 1 within 100 cycles", cpu_ready);
    end
    cpu_req = 1'b1; cpu_is_rd = rd; cpu_addr = a; cpu_wdata = wd;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    l = 0;
    while (cpu_done !== 1'b1 && l < 100) begin
      @(posedge clk); #1; l++;
    end
    rv = cpu_rdata;
    ev = cpu_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({cpu_ready, cpu_done, cpu_rdata, cpu_err, mem_start, mem_is_rd, mem_addr, mem_wdata} !== 101'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b done=%b rdata=%h err=%b start=%b is_rd=%b addr=%h wdata=%h, required all 0",
               cpu_ready, cpu_done, cpu_rdata, cpu_err, mem_start, mem_is_rd, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (cpu_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL init_not_ready: cycle %0d cpu_ready=%b, required 0", i, cpu_ready);
      end
    end
    init_req++;
    @(posedge clk); #1;
    n_checks++;
    if (cpu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL init_ready: cpu_ready=%b, required 1 after memory finish", cpu_ready);
    end
    n_checks++;
    if (start_cnt !== 0) begin
      n_fail++;
      $display("FAIL init_no_start: mem_start count=%0d, required 0", start_cnt);
    end
  endtask

  task automatic test_write_miss();
    int s, d;
    s = start_cnt; d = done_cnt;
    do_req(1'b0, 16'h0012, 16'hBEEF, lat, rdat, er);
    n_checks++;
    if (lat !== 6 || er !== 1'b0 || rdat !== 16'h0000) begin
      n_fail++;
      $display("FAIL wr_miss_done: lat=%0d err=%b rdata=%h, required 6/0/0000", lat, er, rdat);
    end
    n_checks++;
    if (start_cnt !== s + 2 || last_rd_addr !== 16'h0010 || last_addr !== 16'h0010 || last_is_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_miss_reqs: starts=%0d rd_addr=%h last_addr=%h last_rd=%b, required %0d/0010/0010/0",
               start_cnt - s, last_rd_addr, last_addr, last_is_rd, 2);
    end
    n_checks++;
    if (last_wdata !== 64'h0016_0014_BEEF_0010) begin
      n_fail++;
      $display("FAIL wr_miss_wdata: mem_wdata=%h, required 0016_0014_beef_0010", last_wdata);
    end
    n_checks++;
    if (done_cnt !== d + 1) begin
      n_fail++;
      $display("FAIL wr_miss_pulses: cpu_done pulses=%0d, required 1", done_cnt - d);
    end
  endtask

  task automatic test_read_hit();
    int s;
    s = start_cnt;
    do_req(1'b1, 16'h0012, 16'h0000, lat, rdat, er);
    n_checks++;
    if (lat !== 0 || rdat !== 16'hBEEF || er !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_hit: lat=%0d rdata=%h err=%b, required 0/beef/0", lat, rdat, er);
    end
    n_checks++;
    if (start_cnt !== s) begin
      n_fail++;
      $display("FAIL rd_hit_no_mem: starts=%0d, required 0", start_cnt - s);
    end
    n_checks++;
    if (cpu_rdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL rdata_idle: cpu_rdata=%h, required 0000 outside cpu_done", cpu_rdata);
    end
  endtask

  task automatic test_new_block();
    int s;
    s = start_cnt;
    do_req(1'b1, 16'h0018, 16'h0000, lat, rdat, er);
    n_checks++;
    if (lat !== 3 || rdat !== 16'h0018 || start_cnt !== s + 1 || last_addr !== 16'h0018 || last_is_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_miss: lat=%0d rdata=%h starts=%0d addr=%h rd=%b, required 3/0018/1/0018/1",
               lat, rdat, start_cnt - s, last_addr, last_is_rd);
    end
    s = start_cnt;
    do_req(1'b1, 16'h0012, 16'h0000, lat, rdat, er);
    n_checks++;
    if (lat !== 3 || rdat !== 16'hBEEF || start_cnt !== s + 1 || last_addr !== 16'h0010) begin
      n_fail++;
      $display("FAIL rd_remiss: lat=%0d rdata=%h starts=%0d addr=%h, required 3/beef/1/0010",
               lat, rdat, start_cnt - s, last_addr);
    end
  endtask

  task automatic test_wrap_and_write_hit();
    int s;
    s = start_cnt;
    do_req(1'b0, 16'hFFFE, 16'h1234, lat, rdat, er);
    n_checks++;
    if (lat !== 6 || start_cnt !== s + 2 || last_rd_addr !== 16'hFFF8 || last_addr !== 16'hFFF8) begin
      n_fail++;
      $display("FAIL wrap_wr: lat=%0d starts=%0d rd_addr=%h addr=%h, required 6/2/fff8/fff8",
               lat, start_cnt - s, last_rd_addr, last_addr);
    end
    n_checks++;
    if (last_wdata !== 64'h1234_FFFC_FFFA_FFF8) begin
      n_fail++;
      $display("FAIL wrap_wdata: mem_wdata=%h, required 1234_fffc_fffa_fff8", last_wdata);
    end
    s = start_cnt;
    do_req(1'b1, 16'hFFFE, 16'h0000, lat, rdat, er);
    n_checks++;
    if (lat !== 0 || rdat !== 16'h1234 || start_cnt !== s) begin
      n_fail++;
      $display("FAIL wrap_rd: lat=%0d rdata=%h starts=%0d, required 0/1234/0", lat, rdat, start_cnt - s);
    end
    do_req(1'b0, 16'hFFFA, 16'h5555, lat, rdat, er);
    n_checks++;
    if (lat !== 3 || start_cnt !== s + 1 || last_is_rd !== 1'b0 || last_wdata !== 64'h1234_FFFC_5555_FFF8) begin
      n_fail++;
      $display("FAIL wr_hit: lat=%0d starts=%0d rd=%b wdata=%h, required 3/1/0/1234_fffc_5555_fff8",
               lat, start_cnt - s, last_is_rd, last_wdata);
    end
    do_req(1'b1, 16'hFFFA, 16'h0000, lat, rdat, er);
    n_checks++;
    if (lat !== 0 || rdat !== 16'h5555) begin
      n_fail++;
      $display("FAIL wr_hit_rd: lat=%0d rdata=%h, required 0/5555", lat, rdat);
    end
  endtask

  task automatic test_timeout();
    int s;
    hold_finish = 1'b1;
    do_req(1'b1, 16'h0200, 16'h0000, lat, rdat, er);
    hold_finish = 1'b0;
    n_checks++;
    if (lat !== 16 || er !== 1'b1 || rdat !== 16'h0000) begin
      n_fail++;
      $display("FAIL timeout: lat=%0d err=%b rdata=%h, required 16/1/0000", lat, er, rdat);
    end
    s = start_cnt;
    do_req(1'b1, 16'h0200, 16'h0000, lat, rdat, er);
    n_checks++;
    if (lat !== 3 || er !== 1'b0 || rdat !== 16'h0200 || start_cnt !== s + 1) begin
      n_fail++;
      $display("FAIL timeout_remiss: lat=%0d err=%b rdata=%h starts=%0d, required 3/0/0200/1",
               lat, er, rdat, start_cnt - s);
    end
    do_req(1'b1, 16'h0204, 16'h0000, lat, rdat, er);
    n_checks++;
    if (lat !== 0 || rdat !== 16'h0204) begin
      n_fail++;
      $display("FAIL lane2_hit: lat=%0d rdata=%h, required 0/0204", lat, rdat);
    end
  endtask

  task automatic test_busy_ignore();
    int s, d, g;
    s = start_cnt; d = done_cnt;
    cpu_req = 1'b1; cpu_is_rd = 1'b1; cpu_addr = 16'h0300;
    @(posedge clk); #1;
    cpu_addr = 16'h0400;
    repeat (2) begin @(posedge clk); #1; end
    cpu_req = 1'b0;
    g = 0;
    while (cpu_done !== 1'b1 && g < 50) begin
      @(posedge clk); #1; g++;
    end
    n_checks++;
    if (cpu_done !== 1'b1 || cpu_rdata !== 16'h0300) begin
      n_fail++;
      $display("FAIL busy_done: done=%b rdata=%h, required 1/0300", cpu_done, cpu_rdata);
    end
    repeat (4) begin @(posedge clk); #1; end
    n_checks++;
    if (start_cnt !== s + 1 || done_cnt !== d + 1 || cpu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_ignored: starts=%0d dones=%0d ready=%b, required 1/1/1",
               start_cnt - s, done_cnt - d, cpu_ready);
    end
  endtask

  task automatic test_reset_abort();
    int d;
    d = done_cnt;
    cpu_req = 1'b1; cpu_is_rd = 1'b1; cpu_addr = 16'h0100;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({cpu_ready, cpu_done, mem_start, cpu_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_reset_out: ready=%b done=%b start=%b err=%b, required 0000",
               cpu_ready, cpu_done, mem_start, cpu_err);
    end
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    n_checks++;
    if (done_cnt !== d || cpu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: dones=%0d ready=%b, required 0/0", done_cnt - d, cpu_ready);
    end
    init_req++;
    @(posedge clk); #1;
    do_req(1'b1, 16'h0012, 16'h0000, lat, rdat, er);
    n_checks++;
    if (lat !== 3 || rdat !== 16'hBEEF || done_cnt !== d + 1) begin
      n_fail++;
      $display("FAIL abort_recover: lat=%0d rdata=%h dones=%0d, required 3/beef/1", lat, rdat, done_cnt - d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_miss();
    test_read_hit();
    test_new_block();
    test_wrap_and_write_hit();
    test_timeout();
    test_busy_ignore();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
